pic_bus_interface: RTL
======================

// Module: pic_bus_interface
// PURPOSE
//  Parametrised, clocked successor to the PIC data bus buffer.
//  - Synchronises the CPU strobes (CS_N/RD_N/WR_N) into the PIC clock domain.
//  - Captures CPU write cycles into a small write FIFO for the control logic.
//  - Fetches and holds read data, then drives the bidirectional bus only during a valid read.
//  - Sits between the CPU pins and the PIC command/register logic.
// PARAMETERS
//  DATA_W      8  width of data_bus and internal data paths
//  ADDR_W      1  width of CPU address (A0 for 8259)
//  FIFO_DEPTH  4  write FIFO entries; power of two, >=2
//  SYNC_STAGES 2  flops per strobe synchroniser; >=2
// PORTS
//  clk       in    1                    PIC clock, all state on rising edge
//  rst_n     in    1                    async active-low reset
//  cs_n      in    1                    CPU chip select, async
//  rd_n      in    1                    CPU read strobe, async
//  wr_n      in    1                    CPU write strobe, async
//  addr      in    ADDR_W               CPU address
//  data_bus  inout DATA_W               CPU data bus; tristated unless driving a read
//  wr_valid  out   1                    FIFO head valid
//  wr_data   out   DATA_W               FIFO head data
//  wr_addr   out   ADDR_W               FIFO head address
//  wr_ready  in    1                    core pops head when wr_valid & wr_ready
//  rd_req    out   1                    one-cycle read request to core
//  rd_addr   out   ADDR_W               address for rd_req, held until next request
//  rd_data   in    DATA_W               core read data, valid the cycle after rd_req
//  ovf       out   1                    sticky: write pushed while FIFO full
//  proto_err out   1                    sticky: rd and wr active together
//  err_clr   in    1                    clears ovf and proto_err
// BEHAVIOUR
//  Reset
//   - All outputs 0, data_bus = 'z, FIFO empty, FSM = IDLE.
//   - Synchronisers preset to 1 (inactive).
//  Strobes
//   - wr_s = sync(!cs_n & !wr_n); rd_s = sync(!cs_n & !rd_n).
//   - Latency: SYNC_STAGES clocks.
//   - CPU strobe low time must be >= SYNC_STAGES+2 clocks.
//  FSM (one-hot or encoded)
//   - IDLE
//       rd_s & wr_s -> ERR, set proto_err
//       wr_s        -> WR
//       rd_s        -> RD_REQ
//   - WR
//       Each cycle, capture data_bus and addr into a staging reg.
//       !wr_s -> push staging reg into FIFO, go IDLE.
//       rd_s  -> ERR, set proto_err, no push.
//   - RD_REQ
//       rd_req=1, rd_addr=addr for exactly one cycle -> RD_WAIT.
//   - RD_WAIT
//       Load rd_hold <= rd_data -> RD_DRIVE.
//   - RD_DRIVE
//       data_bus = rd_hold.
//       !rd_s -> release data_bus same cycle, go IDLE.
//       wr_s  -> ERR.
//   - ERR
//       data_bus = 'z, no push.
//       Return to IDLE when !rd_s & !wr_s.
//  FIFO
//   - Write push occurs one cycle after wr_s falls; data is the last cycle's sample.
//   - Push when full: entry dropped, ovf set, contents unchanged.
//   - Push and pop in the same cycle: count unchanged, even when full.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Count width is $clog2(FIFO_DEPTH)+1.
//   - Empty: wr_valid=0; wr_data/wr_addr hold last head value (don't care).
//  Bus drive
//   - data_bus is driven only in RD_DRIVE; never driven in any other state.
//   - A read never overlaps a write.
//  Errors
//   - err_clr clears ovf and proto_err.
//   - err_clr in the same cycle as a new error event: the error wins, flag stays 1.
//  Reset mid-cycle
//   - data_bus released immediately (async), FIFO flushed.
//   - The CPU cycle in progress is lost.
// STRUCTURE
//  - Shared package pic_pkg: FSM state typedef (IDLE, WR, RD_REQ, RD_WAIT,
//    RD_DRIVE, ERR), default DATA_W/ADDR_W constants.
//  - Sub-module pic_sync_fifo: parametrised width/depth FIFO with push, pop,
//    full, empty, count.
//  - The strobe synchroniser is an inline generate loop.
// TESTING
//  1. Reset
//     - Release rst_n.
//     -> data_bus='z, wr_valid=0, ovf=0, proto_err=0, rd_req=0.
//  2. Single write
//     - CPU writes 8'hA5, addr=1, wr_n low 6 clocks, wr_ready=0.
//     -> wr_valid=1, wr_data=A5, wr_addr=1 within SYNC_STAGES+2 clocks of wr_n rising.
//  3. Read
//     - CPU read, addr=0, core rd_data=8'h3C.
//     -> one rd_req pulse with rd_addr=0.
//     -> data_bus=3C while rd_s high.
//     -> 'z within SYNC_STAGES+1 clocks of rd_n rising.
//  4. Overflow
//     - 5 writes (11,22,33,44,55), wr_ready=0, DEPTH=4.
//     -> ovf=1, FIFO holds 11,22,33,44.
//     -> Pop order 11,22,33,44 with wr_ready=1.
//  5. Protocol error and clear
//     - rd_n and wr_n low together.
//     -> proto_err=1, no push, data_bus='z.
//     - Pulse err_clr after the strobes release.
//     -> proto_err=0.
//  6. Reset during RD_DRIVE
//     - Assert rst_n while data_bus is driven.
//     -> data_bus='z immediately, FIFO empty.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC CPU bus interface: FSM states, default widths
// and the sticky error-flag update rule.
package pic_pkg;

    localparam int PIC_DATA_W = 8;
    localparam int PIC_ADDR_W = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_DRIVE,
        ERR
    } pic_state_e;

    // A new error event in the same cycle as a clear keeps the flag set.
    function automatic logic sticky_next(input logic flag, input logic set, input logic clr);
        return set | (flag & ~clr);
    endfunction

endpackage

// File: rtl/pic_sync_fifo.sv
// First-word-fall-through FIFO carrying captured CPU writes to the core.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module pic_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/pic_bus_interface.sv
// Clocked CPU data-bus front end for the PIC: strobe synchronisers, write
// capture FIFO, read fetch/hold and tristate bus drive.
module pic_bus_interface
    import pic_pkg::*;
#(
    parameter int DATA_W      = PIC_DATA_W,
    parameter int ADDR_W      = PIC_ADDR_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              wr_valid,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              ovf,
    output logic              proto_err,
    input  logic              err_clr
);

    localparam int FW = DATA_W + ADDR_W;

    // Synchronisers carry the active-low strobes, so a preset of 1 means idle.
    logic [SYNC_STAGES-1:0] wr_sync_reg;
    logic [SYNC_STAGES-1:0] rd_sync_reg;
    logic                   wr_s;
    logic                   rd_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        wr_sync_reg[0] <= 1'b1;
                        rd_sync_reg[0] <= 1'b1;
                    end else begin
                        wr_sync_reg[0] <= cs_n | wr_n;
                        rd_sync_reg[0] <= cs_n | rd_n;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        wr_sync_reg[gi] <= 1'b1;
                        rd_sync_reg[gi] <= 1'b1;
                    end else begin
                        wr_sync_reg[gi] <= wr_sync_reg[gi-1];
                        rd_sync_reg[gi] <= rd_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign wr_s = ~wr_sync_reg[SYNC_STAGES-1];
    assign rd_s = ~rd_sync_reg[SYNC_STAGES-1];

    pic_state_e        state_reg, state_next;
    logic [FW-1:0]     stage_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [DATA_W-1:0] rd_hold_reg;
    logic              ovf_reg;
    logic              proto_err_reg;
    logic              fifo_push;
    logic              perr_event;
    logic              load_rd_addr;
    logic              drive;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_comb begin
        state_next   = state_reg;
        fifo_push    = 1'b0;
        perr_event   = 1'b0;
        load_rd_addr = 1'b0;
        drive        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_s && wr_s) begin
                    state_next = ERR;
                    perr_event = 1'b1;
                end else if (wr_s) begin
                    state_next = WR;
                end else if (rd_s) begin
                    state_next   = RD_REQ;
                    load_rd_addr = 1'b1;
                end
            end
            WR: begin
                if (rd_s) begin
                    state_next = ERR;
                    perr_event = 1'b1;
                end else if (!wr_s) begin
                    fifo_push  = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = RD_DRIVE;
            RD_DRIVE: begin
                if (wr_s) begin
                    state_next = ERR;
                    perr_event = 1'b1;
                end else if (!rd_s) begin
                    state_next = IDLE;
                end else begin
                    drive = 1'b1;
                end
            end
            ERR: begin
                if (!rd_s && !wr_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            stage_reg     <= '0;
            rd_addr_reg   <= '0;
            rd_hold_reg   <= '0;
            ovf_reg       <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == WR && wr_s) begin
                stage_reg <= {addr, data_bus};
            end
            if (load_rd_addr) begin
                rd_addr_reg <= addr;
            end
            if (state_reg == RD_WAIT) begin
                rd_hold_reg <= rd_data;
            end
            // A full FIFO still accepts the push when the head is popped alongside it.
            ovf_reg       <= sticky_next(ovf_reg,
                                         fifo_push & fifo_full & ~(wr_ready & ~fifo_empty),
                                         err_clr);
            proto_err_reg <= sticky_next(proto_err_reg, perr_event, err_clr);
        end
    end

    pic_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (wr_ready),
        .din   (stage_reg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid           = (fifo_count != '0);
    assign {wr_addr, wr_data} = fifo_dout;
    assign rd_req             = (state_reg == RD_REQ);
    assign rd_addr            = rd_addr_reg;
    assign ovf                = ovf_reg;
    assign proto_err          = proto_err_reg;
    assign data_bus           = drive ? rd_hold_reg : {DATA_W{1'bz}};

endmodule
